uart_word_rx: RTL and testbench
===============================

# uart_word_rx

Receive-side front end for the UART DMA path. It samples the raw `uart_rxd` pin, deserialises 8N1 frames, and packs every three received bytes into one 18-bit word. Each word is presented on a valid/ready port to the DMA stage that writes words into the dcache. It also reports framing errors and word overruns so the control unit can abort a load.

## Interface
Parameters:
- `CLK_HZ`, 50000000: system clock frequency in Hz.
- `BAUD`, 115200: line rate. Derived `CLKS_PER_BIT = CLK_HZ/BAUD` (integer division, must be ≥ 4). Derived `HALF_BIT = CLKS_PER_BIT/2`.

Ports:
- `clk`, input, 1: system clock; all state on rising edge.
- `reset`, input, 1: asynchronous, active-low reset (0 = reset).
- `uart_rxd`, input, 1: raw asynchronous UART receive pin; idle high.
- `flush`, input, 1: synchronous; discards the partial word and clears `overrun`.
- `word_valid`, output, 1: output register holds a word.
- `word_ready`, input, 1: consumer accepts the word when `word_valid & word_ready`.
- `word_data`, output, 18: assembled word.
- `frame_err`, output, 1: one-cycle pulse on a bad stop bit.
- `overrun`, output, 1: sticky; a completed word was dropped because the output register was full.

## Operation
- **Input synchroniser**
  - `uart_rxd` passes through a 2-flop synchroniser; both flops reset to 1.
  - All decisions use the synchronised bit `rx_s`.
- **FSM states:** IDLE, START, DATA, STOP, BREAK. A bit counter counts to `CLKS_PER_BIT-1` and a 3-bit index tracks data bits.
- **IDLE:** on `rx_s==0`, go to START with the counter at 0.
- **START:** at count `HALF_BIT-1`, re-sample.
  - `rx_s==1`: glitch, return to IDLE, no output.
  - `rx_s==0`: go to DATA with the counter cleared.
- **DATA:** sample `rx_s` each time the count reaches `CLKS_PER_BIT-1`, which is mid-bit. Shift LSB first into the byte. After bit 7, go to STOP.
- **STOP:** at count `CLKS_PER_BIT-1`, sample.
  - `rx_s==1`: byte good, return to IDLE.
  - `rx_s==0`: pulse `frame_err`, discard the byte, clear the byte index to 0, go to BREAK.
- **BREAK:** wait for `rx_s==1`, then go to IDLE.
- **Word packing:** the byte index cycles 0, 1, 2.
  - byte0 → `word[7:0]`.
  - byte1 → `word[15:8]`.
  - byte2 bits[1:0] → `word[17:16]`; byte2 bits[7:2] are ignored.
- **Word completion:** when byte2 completes, the byte index returns to 0.
  - If the output register is empty, or is being drained in the same cycle (`word_valid & word_ready`), load it and assert `word_valid`.
  - Otherwise drop the new word and set `overrun`. The held word is not modified.
- **Output hold:** `word_valid` and `word_data` are held stable until the handshake. `word_data` is don't-care while `word_valid==0`, but is held at its last value.
- **flush:**
  - Clears the byte index and `overrun`.
  - Does not disturb the FSM mid-frame; the byte in flight, if completed, counts as byte0.
  - Does not clear a pending output word.
- **Simultaneous events:**
  - `flush` in the same cycle as a byte2 completion: the flush wins, the word is discarded, and `overrun` is not set.
  - A handshake in the same cycle as a word load: the new word replaces the old one and `word_valid` stays 1.
- **Reset mid-frame:** all state returns to reset values immediately; the frame is lost. After reset release, reception resumes at the next falling edge.

## Timing
- **Reset values:** `word_valid=0`, `word_data=0`, `frame_err=0`, `overrun=0`, FSM=IDLE, byte index=0, synchroniser flops=1.
- **Pin to FSM:** 2 cycles through the synchroniser.
- **Start to first data sample:** `HALF_BIT + CLKS_PER_BIT` cycles after the synchronised falling edge.
- **Word latency:** `word_valid` rises on the clock edge after the byte2 stop-bit sample.
- **Status pulses:** `frame_err` is high for exactly 1 cycle, in the cycle after the bad stop sample.
- **Handshake:** `word_valid` falls on the edge after `word_valid & word_ready`, unless a new word loads in that same cycle. There is no combinational path from `word_ready` to `word_valid`.
- **Throughput:** one word per 30 bit-times. The consumer has 30 bit-times to accept before an overrun can occur.

## Test plan
All scenarios use `CLK_HZ=1000000`, `BAUD=100000` (10 clocks/bit).
- **Basic word:** send bytes 0x34, 0x12, 0xFE with `word_ready=1` → one `word_valid` pulse with `word_data=18'h21234`. No `frame_err`, no `overrun`.
- **Start glitch:** drive `uart_rxd` low for 3 clocks, then high → no byte recorded. The next 3 good bytes 0x01, 0x00, 0x00 give `word_data=18'h00001`.
- **Framing error:** send 0xAA with the stop bit low for 1 bit, release, then send 0x01, 0x02, 0x03 → one `frame_err` pulse and `word_data=18'h30201`. The 0xAA byte is discarded and packing restarts.
- **Overrun:** hold `word_ready=0` and send 6 bytes forming words 0x00001 and 0x00002 → `overrun=1`, `word_data` stays 18'h00001. Raising `word_ready` gives exactly one handshake. A later `flush` clears `overrun`.
- **Flush and reset mid-word:** send 0x55, then pulse `flush`, then send 0x11, 0x22, 0x03 → `word_data=18'h32211`. Asserting `reset` low mid-byte clears `word_valid` and the FSM the same cycle, and the next full word is received correctly.

Source files
------------

// File: rtl/uart_word_rx.sv
// UART 8N1 receiver that packs every three received bytes into one 18-bit word
// and offers it on a valid/ready port, with framing-error and overrun status.
`timescale 1ns/1ps
module uart_word_rx #(
   parameter int CLK_HZ = 50000000,
   parameter int BAUD   = 115200
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        uart_rxd,
   input  logic        flush,
   output logic        word_valid,
   input  logic        word_ready,
   output logic [17:0] word_data,
   output logic        frame_err,
   output logic        overrun
);

   localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } state_t;

   // Stage p0/p1: two-flop synchroniser, idles high so reset never looks like a start bit
   logic rx_meta_p0;
   logic rx_s;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_meta_p0 <= 1'b1;
         rx_s       <= 1'b1;
      end else begin
         rx_meta_p0 <= uart_rxd;
         rx_s       <= rx_meta_p0;
      end
   end

   // Bit-level FSM
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic             shift_en;
   logic             byte_done;
   logic             stop_bad;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + 1'b1;
      bit_d     = bit_q;
      shift_en  = 1'b0;
      byte_done = 1'b0;
      stop_bad  = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            bit_d = '0;
            if (!rx_s) state_d = START;
         end
         START: begin
            // Half a bit in: a high line here means the falling edge was a glitch
            if (cnt_q == CNT_HALF) begin
               cnt_d   = '0;
               state_d = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d    = '0;
               shift_en = 1'b1;
               bit_d    = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = STOP;
            end
         end
         STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (rx_s) begin
                  byte_done = 1'b1;
                  state_d   = IDLE;
               end else begin
                  stop_bad = 1'b1;
                  state_d  = BREAK;
               end
            end
         end
         BREAK: begin
            cnt_d = '0;
            if (rx_s) state_d = IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   // Byte shifter, LSB first; pure data path so it carries no reset
   logic [7:0] shreg;

   always_ff @(posedge clk) begin
      if (shift_en) shreg <= {rx_s, shreg[7:1]};
   end

   // Word packing and output register
   logic [1:0]  byte_idx_q;
   logic [15:0] word_lo;
   logic        hs;
   logic        word_done;
   logic        load;

   assign hs        = word_valid & word_ready;
   assign word_done = byte_done & (byte_idx_q == 2'd2) & ~flush;
   // Loading while the held word drains in the same cycle is allowed
   assign load      = word_done & (~word_valid | word_ready);

   always_ff @(posedge clk) begin
      if (byte_done && !flush) begin
         case (byte_idx_q)
            2'd0:    word_lo[7:0]  <= shreg;
            2'd1:    word_lo[15:8] <= shreg;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         byte_idx_q <= '0;
         overrun    <= 1'b0;
         word_valid <= 1'b0;
         word_data  <= '0;
         frame_err  <= 1'b0;
      end else begin
         if (flush || stop_bad)
            byte_idx_q <= '0;
         else if (byte_done)
            byte_idx_q <= (byte_idx_q == 2'd2) ? 2'd0 : byte_idx_q + 2'd1;

         if (flush)
            overrun <= 1'b0;
         else if (word_done && !load)
            overrun <= 1'b1;

         if (load)
            word_valid <= 1'b1;
         else if (hs)
            word_valid <= 1'b0;

         if (load)
            word_data <= {shreg[1:0], word_lo};

         frame_err <= stop_bad;
      end
   end

endmodule

// File: tb/tb_uart_word_rx.sv
// Directed bench for uart_word_rx at 10 clocks per bit.
`timescale 1ns/1ps
module tb_uart_word_rx;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        uart_rxd = 1'b1;
   logic        flush = 1'b0;
   logic        word_ready = 1'b0;
   logic        word_valid;
   logic [17:0] word_data;
   logic        frame_err;
   logic        overrun;

   int vecs = 0;
   int errs = 0;

   int          hs_total = 0;
   int          ferr_total = 0;
   logic [17:0] hs_last = '0;

   uart_word_rx #(.CLK_HZ(1000000), .BAUD(100000)) dut (
      .clk        (clk),
      .reset      (reset),
      .uart_rxd   (uart_rxd),
      .flush      (flush),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .word_data  (word_data),
      .frame_err  (frame_err),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   // Passive monitor: handshakes and frame_err high cycles
   always @(posedge clk) begin
      if (word_valid && word_ready) begin
         hs_total = hs_total + 1;
         hs_last  = word_data;
      end
      if (frame_err) ferr_total = ferr_total + 1;
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_val);
      uart_rxd = 1'b0;
      repeat (10) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rxd = b[i];
         repeat (10) @(negedge clk);
      end
      uart_rxd = stop_val;
      repeat (10) @(negedge clk);
      uart_rxd = 1'b1;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      idle(3);
      vecs++; if (word_valid !== 1'b0) begin errs++; $display("FAIL rst_valid got %b want 0", word_valid); end
      vecs++; if (word_data !== 18'h0) begin errs++; $display("FAIL rst_data got %h want 00000", word_data); end
      vecs++; if (frame_err !== 1'b0) begin errs++; $display("FAIL rst_ferr got %b want 0", frame_err); end
      vecs++; if (overrun !== 1'b0) begin errs++; $display("FAIL rst_overrun got %b want 0", overrun); end
      reset = 1'b1;
      idle(5);
   endtask

   task automatic test_basic_word;
      int h0, f0;
      h0 = hs_total; f0 = ferr_total;
      word_ready = 1'b1;
      send_byte(8'h34, 1'b1);
      send_byte(8'h12, 1'b1);
      send_byte(8'hFE, 1'b1);
      idle(5);
      vecs++; if (hs_total - h0 !== 1) begin errs++; $display("FAIL basic_hs got %0d want 1", hs_total - h0); end
      vecs++; if (hs_last !== 18'h21234) begin errs++; $display("FAIL basic_data got %h want 21234", hs_last); end
      vecs++; if (ferr_total - f0 !== 0) begin errs++; $display("FAIL basic_ferr got %0d want 0", ferr_total - f0); end
      vecs++; if (overrun !== 1'b0) begin errs++; $display("FAIL basic_overrun got %b want 0", overrun); end
   endtask

   task automatic test_start_glitch;
      int h0;
      h0 = hs_total;
      uart_rxd = 1'b0;
      idle(3);
      uart_rxd = 1'b1;
      idle(30);
      vecs++; if (hs_total - h0 !== 0) begin errs++; $display("FAIL glitch_nohs got %0d want 0", hs_total - h0); end
      send_byte(8'h01, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      idle(5);
      vecs++; if (hs_total - h0 !== 1) begin errs++; $display("FAIL glitch_hs got %0d want 1", hs_total - h0); end
      vecs++; if (hs_last !== 18'h00001) begin errs++; $display("FAIL glitch_data got %h want 00001", hs_last); end
   endtask

   task automatic test_frame_err;
      int h0, f0;
      h0 = hs_total; f0 = ferr_total;
      send_byte(8'hAA, 1'b0);
      idle(20);
      vecs++; if (ferr_total - f0 !== 1) begin errs++; $display("FAIL ferr_pulse got %0d cycles want 1", ferr_total - f0); end
      send_byte(8'h01, 1'b1);
      send_byte(8'h02, 1'b1);
      send_byte(8'h03, 1'b1);
      idle(5);
      vecs++; if (hs_total - h0 !== 1) begin errs++; $display("FAIL ferr_hs got %0d want 1", hs_total - h0); end
      vecs++; if (hs_last !== 18'h30201) begin errs++; $display("FAIL ferr_data got %h want 30201", hs_last); end
      vecs++; if (ferr_total - f0 !== 1) begin errs++; $display("FAIL ferr_total got %0d want 1", ferr_total - f0); end
   endtask

   task automatic test_overrun;
      int h0;
      word_ready = 1'b0;
      idle(5);
      h0 = hs_total;
      send_byte(8'h01, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      vecs++; if (overrun !== 1'b0) begin errs++; $display("FAIL ovr_early got %b want 0", overrun); end
      send_byte(8'h02, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      idle(2);
      vecs++; if (overrun !== 1'b1) begin errs++; $display("FAIL ovr_set got %b want 1", overrun); end
      vecs++; if (word_valid !== 1'b1) begin errs++; $display("FAIL ovr_valid got %b want 1", word_valid); end
      vecs++; if (word_data !== 18'h00001) begin errs++; $display("FAIL ovr_held got %h want 00001", word_data); end
      word_ready = 1'b1;
      idle(3);
      word_ready = 1'b0;
      vecs++; if (hs_total - h0 !== 1) begin errs++; $display("FAIL ovr_hs got %0d want 1", hs_total - h0); end
      vecs++; if (hs_last !== 18'h00001) begin errs++; $display("FAIL ovr_hsdata got %h want 00001", hs_last); end
      vecs++; if (word_valid !== 1'b0) begin errs++; $display("FAIL ovr_drained got %b want 0", word_valid); end
      vecs++; if (overrun !== 1'b1) begin errs++; $display("FAIL ovr_sticky got %b want 1", overrun); end
      flush = 1'b1;
      idle(1);
      flush = 1'b0;
      idle(1);
      vecs++; if (overrun !== 1'b0) begin errs++; $display("FAIL ovr_flush got %b want 0", overrun); end
   endtask

   task automatic test_flush;
      int h0;
      word_ready = 1'b1;
      h0 = hs_total;
      send_byte(8'h55, 1'b1);
      idle(3);
      flush = 1'b1;
      idle(1);
      flush = 1'b0;
      idle(3);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      send_byte(8'h03, 1'b1);
      idle(5);
      vecs++; if (hs_total - h0 !== 1) begin errs++; $display("FAIL flush_hs got %0d want 1", hs_total - h0); end
      vecs++; if (hs_last !== 18'h32211) begin errs++; $display("FAIL flush_data got %h want 32211", hs_last); end
   endtask

   task automatic test_reset_mid;
      int h0;
      word_ready = 1'b0;
      send_byte(8'h01, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      idle(2);
      vecs++; if (word_valid !== 1'b1) begin errs++; $display("FAIL rmid_pending got %b want 1", word_valid); end
      // Partial byte 0x11: start bit plus four data bits, then reset
      uart_rxd = 1'b0;
      idle(10);
      for (int i = 0; i < 4; i++) begin
         uart_rxd = (i == 0) ? 1'b1 : 1'b0;
         idle(10);
      end
      reset = 1'b0;
      #1;
      vecs++; if (word_valid !== 1'b0) begin errs++; $display("FAIL rmid_valid got %b want 0", word_valid); end
      vecs++; if (word_data !== 18'h0) begin errs++; $display("FAIL rmid_data got %h want 00000", word_data); end
      idle(2);
      uart_rxd = 1'b1;
      reset = 1'b1;
      idle(20);
      h0 = hs_total;
      word_ready = 1'b1;
      send_byte(8'h44, 1'b1);
      send_byte(8'h33, 1'b1);
      send_byte(8'h01, 1'b1);
      idle(5);
      vecs++; if (hs_total - h0 !== 1) begin errs++; $display("FAIL rmid_hs got %0d want 1", hs_total - h0); end
      vecs++; if (hs_last !== 18'h13344) begin errs++; $display("FAIL rmid_word got %h want 13344", hs_last); end
      vecs++; if (overrun !== 1'b0) begin errs++; $display("FAIL rmid_overrun got %b want 0", overrun); end
   endtask

   initial begin
      test_reset();
      test_basic_word();
      test_start_glitch();
      test_frame_err();
      test_overrun();
      test_flush();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
